dds_phase_accum: RTL and testbench
==================================

// Module: dds_phase_accum
// PURPOSE
//  Phase accumulator stage of the DDS chain. Sits directly upstream of the sine LUT stage.
//  Integrates a frequency tuning word (FTW) every enabled clock and adds a programmable phase offset.
//  Presents a registered PHASE_W-bit phase to the LUT stage.
//  Supports FTW updates that are either immediate or phase-continuous (applied at wrap), plus a linear up-sweep of the FTW.
// PARAMETERS
//  ACC_W    24  accumulator / FTW width in bits
//  PHASE_W  14  output phase width; equals the LUT stage phase input width
// PORTS
//  clk             in   1        system clock, all logic on rising edge
//  rst             in   1        synchronous, active-high reset
//  en              in   1        advance accumulator and sweep this cycle
//  ftw_in          in   ACC_W    new tuning word
//  ftw_load        in   1        1-cycle strobe: capture ftw_in
//  ftw_mode        in   1        0 = apply immediately, 1 = apply at next wrap
//  poff_in         in   PHASE_W  phase offset
//  poff_load       in   1        1-cycle strobe: capture poff_in
//  sweep_start     in   1        level: start/hold linear FTW sweep
//  sweep_step      in   ACC_W    FTW increment per enabled cycle during sweep
//  sweep_stop_ftw  in   ACC_W    sweep end FTW
//  sweep_busy      out  1        high while the sweep FSM is in RAMP
//  wrap            out  1        1-cycle pulse: accumulator carry-out occurred
//  phase_valid     out  1        phase_out is valid (en delayed by 1 cycle)
//  phase_out       out  PHASE_W  phase to the LUT stage
// BEHAVIOUR
//  Reset: acc, ftw_act, ftw_pend, pend_flag and poff are 0; FSM is IDLE.
//    Outputs after reset: phase_out=0, phase_valid=0, wrap=0, sweep_busy=0.
//  Accumulator (en=1): acc <= (acc + ftw_act) mod 2^ACC_W, using the ftw_act value registered before this edge.
//    wrap <= carry-out of that add. en=0: acc frozen, wrap <= 0.
//  Output: phase_out <= (acc[ACC_W-1 -: PHASE_W] + poff) mod 2^PHASE_W, taken from the current acc register.
//    phase_out therefore lags acc by 1 cycle; phase_valid <= en.
//  FTW load, mode 0: ftw_act <= ftw_in at the edge; it is used from the next edge; pend_flag is cleared.
//  FTW load, mode 1: ftw_pend <= ftw_in, pend_flag <= 1.
//    On the edge where the add carries out, ftw_act <= ftw_pend and pend_flag <= 0.
//    The new FTW is used from the following edge.
//    A second mode-1 load before the wrap overwrites ftw_pend.
//  Simultaneous mode-1 load and wrap: the old pending value is applied; the new value becomes pending.
//  poff_load: poff <= poff_in, visible in phase_out 1 cycle later. No wrap wait.
//  Sweep FSM (IDLE, RAMP, HOLD):
//    IDLE -> RAMP on sweep_start=1 if sweep_stop_ftw > ftw_act; otherwise IDLE -> HOLD.
//    RAMP, each en=1 cycle: compute s = ftw_act + sweep_step in ACC_W+1 bits.
//      If s >= sweep_stop_ftw: ftw_act <= sweep_stop_ftw, go to HOLD. Otherwise ftw_act <= s.
//    RAMP with en=0: frozen.
//    HOLD -> IDLE when sweep_start=0. RAMP with sweep_start=0 -> IDLE; ftw_act keeps its current value.
//    Any ftw_load in RAMP or HOLD aborts to IDLE; the load is processed normally.
//    The load has priority over the sweep update in the same cycle.
//    sweep_step=0 in RAMP: ftw_act is unchanged and the FSM stays in RAMP.
//  Loads and poff_load are accepted while en=0; a pending FTW applies only at a real wrap.
//  rst has priority over all inputs, including mid-sweep and with a pending FTW.
// TESTING
//  1. rst=1 for 2 clocks with random inputs -> all outputs 0 and FSM IDLE on the cycle after rst falls.
//  2. Mode-0 load of ftw 0x000400, en=1 -> phase_out increments by 1 per cycle.
//     wrap pulses once every 16384 cycles; phase_valid is high.
//  3. Running at ftw 0x000400, mode-1 load of 0x000800 -> step stays 1 until wrap.
//     Phase-out steps are 2 from 1 cycle after the wrap pulse.
//  4. poff_load of 0x2000 mid-run -> phase_out jumps by +0x2000 mod 2^14 with no glitch in acc.
//  5. ftw_act=0x100, step=0x100, stop=0x480, sweep_start=1 -> ftw_act = 0x200, 0x300, 0x400, 0x480.
//     HOLD follows; sweep_busy is high for 4 cycles.
//  6. A mode-0 ftw_load mid-RAMP -> FSM goes to IDLE, sweep_busy=0, ftw_act = ftw_in.
//     A separate case: en=0 mid-sweep -> ftw_act and acc are frozen.

Source files
------------

// File: rtl/dds_phase_accum.sv
// Phase accumulator for the DDS chain. It applies tuning-word updates either at once or at the next
// wrap, adds a phase offset, and runs a linear FTW up-sweep. The output is a registered phase for the LUT.
module dds_phase_accum #(
    parameter int ACC_W   = 24,
    parameter int PHASE_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [ACC_W-1:0]   ftw_in,
    input  logic               ftw_load,
    input  logic               ftw_mode,
    input  logic [PHASE_W-1:0] poff_in,
    input  logic               poff_load,
    input  logic               sweep_start,
    input  logic [ACC_W-1:0]   sweep_step,
    input  logic [ACC_W-1:0]   sweep_stop_ftw,
    output logic               sweep_busy,
    output logic               wrap,
    output logic               phase_valid,
    output logic [PHASE_W-1:0] phase_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2
    } sweep_state_t;

    function automatic logic [PHASE_W-1:0] phase_add_mod(
        input logic [PHASE_W-1:0] a,
        input logic [PHASE_W-1:0] b
    );
        return a + b;
    endfunction

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ftw_act_q, ftw_act_d;
    logic [ACC_W-1:0]   ftw_pend_q, ftw_pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic [PHASE_W-1:0] poff_q, poff_d;
    sweep_state_t       state_q, state_d;
    logic               wrap_q, wrap_d;
    logic               phase_valid_q, phase_valid_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               sweep_busy_q, sweep_busy_d;

    logic [ACC_W:0]     acc_sum;
    logic [ACC_W:0]     ramp_sum;
    logic               apply_pend;

    assign acc_sum    = {1'b0, acc_q} + {1'b0, ftw_act_q};
    assign ramp_sum   = {1'b0, ftw_act_q} + {1'b0, sweep_step};
    // A pending FTW is applied only on an edge where an enabled add really carries out.
    assign apply_pend = en & acc_sum[ACC_W] & pend_flag_q;

    always_comb begin
        acc_d         = acc_q;
        wrap_d        = 1'b0;
        ftw_act_d     = ftw_act_q;
        ftw_pend_d    = ftw_pend_q;
        pend_flag_d   = pend_flag_q;
        state_d       = state_q;
        poff_d        = poff_load ? poff_in : poff_q;
        phase_valid_d = en;
        phase_d       = phase_add_mod(acc_q[ACC_W-1 -: PHASE_W], poff_q);

        if (en) begin
            acc_d  = acc_sum[ACC_W-1:0];
            wrap_d = acc_sum[ACC_W];
        end

        if (ftw_load) begin
            state_d = S_IDLE;
            if (!ftw_mode) begin
                ftw_act_d   = ftw_in;
                pend_flag_d = 1'b0;
            end else begin
                // On a coincident wrap the older pending word goes live and the new one queues.
                if (apply_pend) begin
                    ftw_act_d = ftw_pend_q;
                end
                ftw_pend_d  = ftw_in;
                pend_flag_d = 1'b1;
            end
        end else begin
            if (apply_pend) begin
                ftw_act_d   = ftw_pend_q;
                pend_flag_d = 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (sweep_start) begin
                        state_d = (sweep_stop_ftw > ftw_act_q) ? S_RAMP : S_HOLD;
                    end
                end
                S_RAMP: begin
                    if (!sweep_start) begin
                        state_d = S_IDLE;
                    end else if (en && !apply_pend) begin
                        if (ramp_sum >= {1'b0, sweep_stop_ftw}) begin
                            ftw_act_d = sweep_stop_ftw;
                            state_d   = S_HOLD;
                        end else begin
                            ftw_act_d = ramp_sum[ACC_W-1:0];
                        end
                    end
                end
                S_HOLD: begin
                    if (!sweep_start) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        sweep_busy_d = (state_d == S_RAMP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= '0;
            ftw_act_q     <= '0;
            ftw_pend_q    <= '0;
            pend_flag_q   <= 1'b0;
            poff_q        <= '0;
            state_q       <= S_IDLE;
            wrap_q        <= 1'b0;
            phase_valid_q <= 1'b0;
            phase_q       <= '0;
            sweep_busy_q  <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            ftw_act_q     <= ftw_act_d;
            ftw_pend_q    <= ftw_pend_d;
            pend_flag_q   <= pend_flag_d;
            poff_q        <= poff_d;
            state_q       <= state_d;
            wrap_q        <= wrap_d;
            phase_valid_q <= phase_valid_d;
            phase_q       <= phase_d;
            sweep_busy_q  <= sweep_busy_d;
        end
    end

    assign sweep_busy  = sweep_busy_q;
    assign wrap        = wrap_q;
    assign phase_valid = phase_valid_q;
    assign phase_out   = phase_q;

endmodule

// File: tb/tb_dds_phase_accum.sv
// Testbench for dds_phase_accum: a table of hand-derived vectors, directed corner sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_dds_phase_accum;

    localparam int     ACC_W   = 24;
    localparam int     PHASE_W = 14;
    localparam int     SH      = ACC_W - PHASE_W;
    localparam longint AMOD    = 64'd1 << ACC_W;
    localparam longint PMOD    = 64'd1 << PHASE_W;

    logic               clk = 1'b0;
    logic               rst, en, ftw_load, ftw_mode, poff_load, sweep_start;
    logic [ACC_W-1:0]   ftw_in, sweep_step, sweep_stop_ftw;
    logic [PHASE_W-1:0] poff_in;
    logic               sweep_busy, wrap, phase_valid;
    logic [PHASE_W-1:0] phase_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dds_phase_accum #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .ftw_in(ftw_in), .ftw_load(ftw_load), .ftw_mode(ftw_mode),
        .poff_in(poff_in), .poff_load(poff_load),
        .sweep_start(sweep_start), .sweep_step(sweep_step), .sweep_stop_ftw(sweep_stop_ftw),
        .sweep_busy(sweep_busy), .wrap(wrap), .phase_valid(phase_valid), .phase_out(phase_out)
    );

    // Reference model: the phase is (acc / 2^SH + poff) mod 2^PHASE_W, and the sweep is a pair of flags.
    longint m_acc, m_ftw, m_pend, m_poff, m_phase;
    bit     m_pf, m_ramp, m_hold, m_valid, m_wrap;

    task automatic model_step();
        longint n_acc, n_ftw, n_pend, s;
        bit     n_pf, n_ramp, n_hold, carry, apply;
        if (rst) begin
            m_acc = 0; m_ftw = 0; m_pend = 0; m_poff = 0; m_phase = 0;
            m_pf = 0; m_ramp = 0; m_hold = 0; m_valid = 0; m_wrap = 0;
            return;
        end
        carry   = en && (m_acc + m_ftw >= AMOD);
        n_acc   = en ? (m_acc + m_ftw) % AMOD : m_acc;
        m_phase = ((m_acc >> SH) + m_poff) % PMOD;
        m_valid = en;
        m_wrap  = carry;
        if (poff_load) m_poff = longint'(poff_in);
        apply  = carry && m_pf;
        n_ftw  = m_ftw; n_pend = m_pend; n_pf = m_pf; n_ramp = m_ramp; n_hold = m_hold;
        if (ftw_load) begin
            n_ramp = 0; n_hold = 0;
            if (!ftw_mode) begin
                n_ftw = longint'(ftw_in); n_pf = 0;
            end else begin
                if (apply) n_ftw = m_pend;
                n_pend = longint'(ftw_in); n_pf = 1;
            end
        end else begin
            if (apply) begin n_ftw = m_pend; n_pf = 0; end
            if (!m_ramp && !m_hold) begin
                if (sweep_start) begin
                    if (longint'(sweep_stop_ftw) > m_ftw) n_ramp = 1;
                    else n_hold = 1;
                end
            end else if (m_hold) begin
                if (!sweep_start) n_hold = 0;
            end else begin
                if (!sweep_start) n_ramp = 0;
                else if (en && !apply) begin
                    s = m_ftw + longint'(sweep_step);
                    if (s >= longint'(sweep_stop_ftw)) begin
                        n_ftw = longint'(sweep_stop_ftw); n_ramp = 0; n_hold = 1;
                    end else begin
                        n_ftw = s;
                    end
                end
            end
        end
        m_acc = n_acc; m_ftw = n_ftw; m_pend = n_pend; m_pf = n_pf;
        m_ramp = n_ramp; m_hold = n_hold;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".phase"}, 32'(phase_out), 32'(m_phase));
        check({tag, ".valid"}, 32'(phase_valid), 32'(m_valid));
        check({tag, ".wrap"},  32'(wrap), 32'(m_wrap));
        check({tag, ".busy"},  32'(sweep_busy), 32'(m_ramp));
    endtask

    typedef struct {
        logic               rst, en, ld, mode, pld, start;
        logic [ACC_W-1:0]   ftw, step, stop;
        logic [PHASE_W-1:0] poff;
        logic [PHASE_W-1:0] e_phase;
        logic               e_valid, e_wrap, e_busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic ld, input logic md,
                                input logic [ACC_W-1:0] f, input logic pl, input logic [PHASE_W-1:0] po,
                                input logic st, input logic [ACC_W-1:0] sp, input logic [ACC_W-1:0] so,
                                input logic [PHASE_W-1:0] ep, input logic ev, input logic ew, input logic eb);
        vec_t v;
        v.rst = r; v.en = e; v.ld = ld; v.mode = md; v.ftw = f; v.pld = pl; v.poff = po;
        v.start = st; v.step = sp; v.stop = so;
        v.e_phase = ep; v.e_valid = ev; v.e_wrap = ew; v.e_busy = eb;
        return v;
    endfunction

    localparam int NV = 23;
    vec_t vt[NV];

    logic [PHASE_W-1:0] prev_phase;
    logic [PHASE_W-1:0] delta;
    int                 nw, w0, w1;
    bit                 got_wrap;

    task automatic tick_delta();
        prev_phase = phase_out;
        tick();
        delta = phase_out - prev_phase;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1; en = 0; ftw_in = '0; ftw_load = 0; ftw_mode = 0; poff_in = '0; poff_load = 0;
        sweep_start = 0; sweep_step = '0; sweep_stop_ftw = '0;
        w0 = 0; w1 = 0;

        //          rst en ld md ftw        pld poff     st step      stop       phase    v  w  b
        vt[0]  = mk(1, 0, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h0000, 0, 0, 0);
        vt[1]  = mk(0, 0, 1, 0, 24'h400000, 0, 14'h0,    0, 24'h0,    24'h0,     14'h0000, 0, 0, 0);
        vt[2]  = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h0000, 1, 0, 0);
        vt[3]  = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h1000, 1, 0, 0);
        vt[4]  = mk(0, 1, 0, 0, 24'h0,      1, 14'h0010, 0, 24'h0,    24'h0,     14'h2000, 1, 0, 0);
        vt[5]  = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h3010, 1, 1, 0);
        vt[6]  = mk(0, 1, 1, 1, 24'h200000, 0, 14'h0,    0, 24'h0,    24'h0,     14'h0010, 1, 0, 0);
        vt[7]  = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h1010, 1, 0, 0);
        vt[8]  = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h2010, 1, 0, 0);
        vt[9]  = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h3010, 1, 1, 0);
        vt[10] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h0010, 1, 0, 0);
        vt[11] = mk(0, 0, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h0810, 0, 0, 0);
        vt[12] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h0810, 1, 0, 0);
        vt[13] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h1010, 1, 0, 0);
        vt[14] = mk(0, 0, 1, 0, 24'h000100, 0, 14'h0,    0, 24'h0,    24'h0,     14'h1810, 0, 0, 0);
        vt[15] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    1, 24'h100,  24'h480,   14'h1810, 1, 0, 1);
        vt[16] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    1, 24'h100,  24'h480,   14'h1810, 1, 0, 1);
        vt[17] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    1, 24'h100,  24'h480,   14'h1810, 1, 0, 1);
        vt[18] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    1, 24'h100,  24'h480,   14'h1811, 1, 0, 1);
        vt[19] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    1, 24'h100,  24'h480,   14'h1811, 1, 0, 0);
        vt[20] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h100,  24'h480,   14'h1812, 1, 0, 0);
        vt[21] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h1813, 1, 0, 0);
        vt[22] = mk(0, 1, 0, 0, 24'h0,      0, 14'h0,    0, 24'h0,    24'h0,     14'h1815, 1, 0, 0);

        for (int i = 0; i < NV; i++) begin
            rst = vt[i].rst; en = vt[i].en; ftw_load = vt[i].ld; ftw_mode = vt[i].mode;
            ftw_in = vt[i].ftw; poff_load = vt[i].pld; poff_in = vt[i].poff;
            sweep_start = vt[i].start; sweep_step = vt[i].step; sweep_stop_ftw = vt[i].stop;
            tick();
            check($sformatf("vec%0d.phase", i), 32'(phase_out),   32'(vt[i].e_phase));
            check($sformatf("vec%0d.valid", i), 32'(phase_valid), 32'(vt[i].e_valid));
            check($sformatf("vec%0d.wrap", i),  32'(wrap),        32'(vt[i].e_wrap));
            check($sformatf("vec%0d.busy", i),  32'(sweep_busy),  32'(vt[i].e_busy));
        end

        // Reset held for two clocks with random inputs clears everything.
        for (int i = 0; i < 2; i++) begin
            rst = 1; en = 1'($urandom); ftw_load = 1'($urandom); ftw_mode = 1'($urandom);
            ftw_in = ACC_W'($urandom); poff_load = 1'($urandom); poff_in = PHASE_W'($urandom);
            sweep_start = 1'($urandom); sweep_step = ACC_W'($urandom); sweep_stop_ftw = ACC_W'($urandom);
            tick();
        end
        check("rst.phase", 32'(phase_out), 32'h0);
        check("rst.valid", 32'(phase_valid), 32'h0);
        check("rst.wrap",  32'(wrap), 32'h0);
        check("rst.busy",  32'(sweep_busy), 32'h0);
        rst = 0; en = 0; ftw_load = 0; poff_load = 0; sweep_start = 0;
        tick(); check_model("post_rst");

        // FTW 0x400: the phase advances by one LSB per cycle and wraps every 16384 cycles.
        en = 1; ftw_load = 1; ftw_mode = 0; ftw_in = 24'h000400; poff_load = 1; poff_in = '0;
        tick(); check_model("t2_load");
        ftw_load = 0; poff_load = 0;
        nw = 0;
        for (int c = 0; c < 40000 && nw < 2; c++) begin
            tick_delta(); check_model("t2");
            if (c >= 1) check("t2_step1", 32'(delta), 32'd1);
            if (wrap) begin
                if (nw == 0) w0 = c; else w1 = c;
                nw++;
            end
        end
        check("t2_wrap_count", 32'(nw), 32'd2);
        check("t2_wrap_period", 32'(w1 - w0), 32'd16384);

        // A mode-1 load of 0x800 keeps step 1 until the wrap, then the step becomes 2.
        ftw_load = 1; ftw_mode = 1; ftw_in = 24'h000800;
        tick_delta(); check_model("t3_load"); check("t3_step_at_load", 32'(delta), 32'd1);
        ftw_load = 0;
        got_wrap = 0;
        for (int c = 0; c < 17000 && !got_wrap; c++) begin
            tick_delta(); check_model("t3_wait");
            check("t3_step_before_wrap", 32'(delta), 32'd1);
            got_wrap = wrap;
        end
        check("t3_wrap_seen", 32'(got_wrap), 32'd1);
        tick_delta(); check_model("t3_e1"); check("t3_step_e1", 32'(delta), 32'd1);
        for (int c = 0; c < 10; c++) begin
            tick_delta(); check_model("t3_after"); check("t3_step2", 32'(delta), 32'd2);
        end

        // A phase-offset load shifts the output once without disturbing the accumulator.
        poff_load = 1; poff_in = 14'h2000;
        tick_delta(); check("t4_before", 32'(delta), 32'd2);
        poff_load = 0;
        tick_delta(); check("t4_jump", 32'(delta), 32'(14'h2002));
        tick_delta(); check("t4_after", 32'(delta), 32'd2);
        check_model("t4");

        // Sweep frozen by en=0, then aborted by a mode-0 load.
        ftw_load = 1; ftw_mode = 0; ftw_in = 24'h001000;
        tick(); check_model("t6_load");
        ftw_load = 0; sweep_start = 1; sweep_step = 24'h000800; sweep_stop_ftw = 24'h010000;
        for (int c = 0; c < 3; c++) begin tick(); check_model("t6_ramp"); end
        check("t6_busy_ramp", 32'(sweep_busy), 32'd1);
        en = 0;
        tick(); check_model("t6_freeze0");
        for (int c = 0; c < 3; c++) begin
            tick_delta(); check_model("t6_freeze");
            check("t6_frozen_phase", 32'(delta), 32'd0);
            check("t6_frozen_busy", 32'(sweep_busy), 32'd1);
        end
        en = 1;
        for (int c = 0; c < 2; c++) begin tick(); check_model("t6_resume"); end
        ftw_load = 1; ftw_mode = 0; ftw_in = 24'h003000;
        tick(); check_model("t6_abort");
        check("t6_abort_busy", 32'(sweep_busy), 32'd0);
        ftw_load = 0; sweep_start = 0;
        tick(); check_model("t6_post1");
        for (int c = 0; c < 4; c++) begin
            tick_delta(); check_model("t6_post");
            check("t6_ftw_new", 32'(delta), 32'd12);
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 9) < 8);
            ftw_load = ($urandom_range(0, 19) == 0);
            ftw_mode = 1'($urandom);
            ftw_in = ($urandom_range(0, 1) == 1) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 32'hFFFF));
            poff_load = ($urandom_range(0, 29) == 0);
            poff_in = PHASE_W'($urandom);
            if ($urandom_range(0, 9) == 0) sweep_start = ~sweep_start;
            sweep_step = ACC_W'($urandom_range(0, 32'h3000));
            sweep_stop_ftw = ACC_W'($urandom_range(0, 32'h100000));
            tick(); check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
